// File: rtl/bank_read_scheduler.sv
// Per-bank round-robin read scheduler with a three-stage response return path.
// Optional macro BANK_CONFLICT_CNT_EN adds saturating per-bank conflict counters.
module bank_read_scheduler #(
    parameter int NUM_BANKS          = 3,
    parameter int SIZE_BANKI         = 32,
    parameter int NUM_RD_PORTS       = 8,
    parameter int DATA_W             = 32,
    parameter int SHIRINA_BANKI      = $clog2(SIZE_BANKI),
    parameter int SHIRINA_VSEH_BANOK = $clog2(SIZE_BANKI * NUM_BANKS)
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [NUM_RD_PORTS-1:0]                         rd_req_valid,
    input  logic [NUM_RD_PORTS-1:0][SHIRINA_VSEH_BANOK-1:0] rd_req_adr,
    output logic [NUM_RD_PORTS-1:0]                         rd_req_ready,
    output logic [NUM_BANKS-1:0]                            bank_rd_en,
    output logic [NUM_BANKS-1:0][SHIRINA_BANKI-1:0]         bank_adr,
    input  logic [NUM_BANKS-1:0][DATA_W-1:0]                bank_rd_data,
    output logic [NUM_RD_PORTS-1:0]                         rd_rsp_valid,
    output logic [NUM_RD_PORTS-1:0][DATA_W-1:0]             rd_rsp_data,
    output logic [NUM_RD_PORTS-1:0]                         rd_rsp_err
`ifdef BANK_CONFLICT_CNT_EN
    ,
    output logic [NUM_BANKS-1:0][15:0]                      conflict_cnt
`endif
);

    localparam int PW        = (NUM_RD_PORTS > 1) ? $clog2(NUM_RD_PORTS) : 1;
    localparam int ADR_LIMIT = NUM_BANKS * SIZE_BANKI;

    logic [NUM_BANKS-1:0][PW-1:0]            r_ptr;
    logic [NUM_BANKS-1:0]                    r_bank_rd_en;
    logic [NUM_BANKS-1:0][SHIRINA_BANKI-1:0] r_bank_adr;
    logic [NUM_BANKS-1:0][PW-1:0]            r_s1_id;
    logic [NUM_BANKS-1:0]                    r_s2_vld;
    logic [NUM_BANKS-1:0][PW-1:0]            r_s2_id;
    logic [NUM_RD_PORTS-1:0]                 r_err_s1;
    logic [NUM_RD_PORTS-1:0]                 r_err_s2;
    logic [NUM_RD_PORTS-1:0]                 r_rsp_valid;
    logic [NUM_RD_PORTS-1:0][DATA_W-1:0]     r_rsp_data;
    logic [NUM_RD_PORTS-1:0]                 r_rsp_err;

    logic [NUM_RD_PORTS-1:0]                 w_oor;
    logic [NUM_BANKS-1:0][NUM_RD_PORTS-1:0]  w_cand;
    logic [NUM_BANKS-1:0]                    w_gnt_vld;
    logic [NUM_BANKS-1:0][PW-1:0]            w_gnt_id;
    logic [NUM_RD_PORTS-1:0]                 w_ready;
    logic [NUM_RD_PORTS-1:0]                 w_rsp_vld;
    logic [NUM_RD_PORTS-1:0][DATA_W-1:0]     w_rsp_data;

    // Candidates and out-of-range accepts are masked by reset so ready is forced low.
    always_comb begin
        w_oor  = '0;
        w_cand = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            w_oor[p] = ({1'b0, rd_req_adr[p]} >= (SHIRINA_VSEH_BANOK + 1)'(ADR_LIMIT));
            for (int b = 0; b < NUM_BANKS; b++) begin
                w_cand[b][p] = rst && rd_req_valid[p] && !w_oor[p] &&
                               ((rd_req_adr[p] >> SHIRINA_BANKI) == SHIRINA_VSEH_BANOK'(b));
            end
        end
    end

    always_comb begin
        logic [PW-1:0] w_idx;
        int            j;
        w_gnt_vld = '0;
        w_gnt_id  = '0;
        w_idx     = '0;
        j         = 0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int i = 0; i < NUM_RD_PORTS; i++) begin
                j = int'(r_ptr[b]) + i;
                if (j >= NUM_RD_PORTS) j = j - NUM_RD_PORTS;
                w_idx = PW'(j);
                if (!w_gnt_vld[b] && w_cand[b][w_idx]) begin
                    w_gnt_vld[b] = 1'b1;
                    w_gnt_id[b]  = w_idx;
                end
            end
        end
    end

    always_comb begin
        w_ready = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            w_ready[p] = rst && rd_req_valid[p] && w_oor[p];
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (w_gnt_vld[b] && (w_gnt_id[b] == PW'(p))) w_ready[p] = 1'b1;
            end
        end
    end

    // At most one bank can target a given port per cycle, so OR-steering is collision free.
    always_comb begin
        w_rsp_vld  = r_err_s2;
        w_rsp_data = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (r_s2_vld[b] && (r_s2_id[b] == PW'(p))) begin
                    w_rsp_vld[p]  = 1'b1;
                    w_rsp_data[p] = w_rsp_data[p] | bank_rd_data[b];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr        <= '0;
            r_bank_rd_en <= '0;
            r_bank_adr   <= '0;
            r_s1_id      <= '0;
            r_s2_vld     <= '0;
            r_s2_id      <= '0;
            r_err_s1     <= '0;
            r_err_s2     <= '0;
            r_rsp_valid  <= '0;
            r_rsp_data   <= '0;
            r_rsp_err    <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_bank_rd_en[b] <= w_gnt_vld[b];
                if (w_gnt_vld[b]) begin
                    r_ptr[b]      <= (w_gnt_id[b] == PW'(NUM_RD_PORTS - 1)) ? '0 : w_gnt_id[b] + 1'b1;
                    r_bank_adr[b] <= rd_req_adr[w_gnt_id[b]][SHIRINA_BANKI-1:0];
                    r_s1_id[b]    <= w_gnt_id[b];
                end
            end
            r_s2_vld    <= r_bank_rd_en;
            r_s2_id     <= r_s1_id;
            r_err_s1    <= rd_req_valid & w_oor;
            r_err_s2    <= r_err_s1;
            r_rsp_valid <= w_rsp_vld;
            r_rsp_data  <= w_rsp_data;
            r_rsp_err   <= r_err_s2;
        end
    end

    assign rd_req_ready = w_ready;
    assign bank_rd_en   = r_bank_rd_en;
    assign bank_adr     = r_bank_adr;
    assign rd_rsp_valid = r_rsp_valid;
    assign rd_rsp_data  = r_rsp_data;
    assign rd_rsp_err   = r_rsp_err;

`ifdef BANK_CONFLICT_CNT_EN
    logic [NUM_BANKS-1:0][15:0] r_conflict_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_conflict_cnt <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (($countones(w_cand[b]) > 1) && (r_conflict_cnt[b] != 16'hFFFF))
                    r_conflict_cnt[b] <= r_conflict_cnt[b] + 16'd1;
            end
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_bank_read_scheduler.sv
// Bench for bank_read_scheduler: directed scenarios plus randomized traffic against a
// cycle-level reference model (round-robin per bank, fixed 3-cycle response latency).
module tb_bank_read_scheduler;

    localparam int NB = 3;
    localparam int NP = 8;
    localparam int DW = 32;
    localparam int BW = 5;
    localparam int AW = 7;
    localparam int LIM = NB * 32;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NP-1:0]              rd_req_valid;
    logic [NP-1:0][AW-1:0]      rd_req_adr;
    logic [NP-1:0]              rd_req_ready;
    logic [NB-1:0]              bank_rd_en;
    logic [NB-1:0][BW-1:0]      bank_adr;
    logic [NB-1:0][DW-1:0]      bank_rd_data;
    logic [NP-1:0]              rd_rsp_valid;
    logic [NP-1:0][DW-1:0]      rd_rsp_data;
    logic [NP-1:0]              rd_rsp_err;
`ifdef BANK_CONFLICT_CNT_EN
    logic [NB-1:0][15:0]        conflict_cnt;
`endif

    always #5 clk = ~clk;

    bank_read_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .rd_req_valid (rd_req_valid),
        .rd_req_adr   (rd_req_adr),
        .rd_req_ready (rd_req_ready),
        .bank_rd_en   (bank_rd_en),
        .bank_adr     (bank_adr),
        .bank_rd_data (bank_rd_data),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_data  (rd_rsp_data),
        .rd_rsp_err   (rd_rsp_err)
`ifdef BANK_CONFLICT_CNT_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [DW-1:0] mem [NB][32];
    int            m_ptr [NB];
    logic          m_en  [NB];
    logic [BW-1:0] m_adr [NB];
    int            m_cnt [NB];
    logic          e_vld  [8][NP];
    logic          e_err  [8][NP];
    logic [DW-1:0] e_data [8][NP];
    logic          prev_en  [NB];
    logic [BW-1:0] prev_adr [NB];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int b = 0; b < NB; b++) begin
            m_ptr[b] = 0; m_en[b] = 1'b0; m_adr[b] = '0; m_cnt[b] = 0;
            prev_en[b] = 1'b0; prev_adr[b] = '0;
        end
        for (int s = 0; s < 8; s++)
            for (int p = 0; p < NP; p++) begin
                e_vld[s][p] = 1'b0; e_err[s][p] = 1'b0; e_data[s][p] = '0;
            end
    endtask

    // One clock: check registered outputs, play bank memory, apply requests, check ready.
    task automatic step(input logic [NP-1:0] v, input logic [NP-1:0][AW-1:0] a,
                        output logic [NP-1:0] acc_o);
        int slot, s3, w, ncand, p, off;
        logic [NP-1:0] exp_rdy;
        @(posedge clk); #1;
        cyc++;
        for (int b = 0; b < NB; b++) begin
            check($sformatf("bank_en[%0d]", b), 64'(bank_rd_en[b]), 64'(m_en[b]));
            check($sformatf("bank_adr[%0d]", b), 64'(bank_adr[b]), 64'(m_adr[b]));
`ifdef BANK_CONFLICT_CNT_EN
            check($sformatf("conflict_cnt[%0d]", b), 64'(conflict_cnt[b]), 64'(m_cnt[b]));
`endif
        end
        slot = cyc % 8;
        for (int q = 0; q < NP; q++) begin
            check($sformatf("rsp_valid[%0d]", q), 64'(rd_rsp_valid[q]), 64'(e_vld[slot][q]));
            check($sformatf("rsp_err[%0d]", q), 64'(rd_rsp_err[q]), 64'(e_err[slot][q]));
            check($sformatf("rsp_data[%0d]", q), 64'(rd_rsp_data[q]), 64'(e_data[slot][q]));
            e_vld[slot][q] = 1'b0; e_err[slot][q] = 1'b0; e_data[slot][q] = '0;
        end
        for (int b = 0; b < NB; b++) begin
            bank_rd_data[b] = prev_en[b] ? mem[b][prev_adr[b]] : $urandom();
            prev_en[b]  = bank_rd_en[b];
            prev_adr[b] = bank_adr[b];
        end
        rd_req_valid = v;
        rd_req_adr   = a;
        #1;
        exp_rdy = '0;
        s3 = (cyc + 3) % 8;
        for (int q = 0; q < NP; q++) begin
            if (v[q] && int'(a[q]) >= LIM) begin
                exp_rdy[q] = 1'b1;
                e_vld[s3][q] = 1'b1; e_err[s3][q] = 1'b1; e_data[s3][q] = '0;
            end
        end
        for (int b = 0; b < NB; b++) begin
            ncand = 0;
            w = -1;
            for (int i = 0; i < NP; i++) begin
                p = (m_ptr[b] + i) % NP;
                if (v[p] && int'(a[p]) < LIM && int'(a[p]) / 32 == b) begin
                    ncand++;
                    if (w < 0) w = p;
                end
            end
            m_en[b] = (w >= 0);
            if (w >= 0) begin
                exp_rdy[w] = 1'b1;
                m_ptr[b] = (w + 1) % NP;
                off = int'(a[w]) % 32;
                m_adr[b] = BW'(off);
                e_vld[s3][w] = 1'b1; e_err[s3][w] = 1'b0; e_data[s3][w] = mem[b][off];
            end
            if (ncand > 1 && m_cnt[b] < 65535) m_cnt[b]++;
        end
        for (int q = 0; q < NP; q++)
            check($sformatf("ready[%0d]", q), 64'(rd_req_ready[q]), 64'(exp_rdy[q]));
        acc_o = exp_rdy;
    endtask

    // Hold reset for n cycles with requests asserted; everything must read zero.
    task automatic reset_seq(input int n);
        @(posedge clk); #1;
        cyc++;
        rst = 1'b0;
        rd_req_valid = '1;
        rd_req_adr   = '1;
        #1;
        check("ready_in_rst", 64'(rd_req_ready), 64'd0);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            cyc++;
            check("rst_ready", 64'(rd_req_ready), 64'd0);
            check("rst_bank_en", 64'(bank_rd_en), 64'd0);
            check("rst_bank_adr", 64'(bank_adr), 64'd0);
            check("rst_rsp_valid", 64'(rd_rsp_valid), 64'd0);
            check("rst_rsp_err", 64'(rd_rsp_err), 64'd0);
            check("rst_rsp_data_or", 64'(|rd_rsp_data), 64'd0);
`ifdef BANK_CONFLICT_CNT_EN
            check("rst_conflict", 64'(|conflict_cnt), 64'd0);
`endif
        end
        rst = 1'b1;
        rd_req_valid = '0;
        rd_req_adr   = '0;
        model_clear();
    endtask

    logic [NP-1:0]         acc;
    logic [NP-1:0]         cv;
    logic [NP-1:0][AW-1:0] ca;
    logic [NP-1:0]         gseq [4];

    initial begin
        rst = 1'b0;
        rd_req_valid = '0;
        rd_req_adr   = '0;
        bank_rd_data = '0;
        for (int b = 0; b < NB; b++)
            for (int i = 0; i < 32; i++) mem[b][i] = $urandom();
        model_clear();
        reset_seq(3);

        // Two ports hitting different banks at the same offset.
        ca = '0; ca[0] = 7'd5; ca[1] = 7'd37;
        step(8'h03, ca, acc);
        check("t1_acc", 64'(acc), 64'h03);
        for (int k = 0; k < 4; k++) step('0, '0, acc);

        // Three ports streaming into bank 2: strict rotation.
        ca = '0; ca[0] = 7'd64; ca[1] = 7'd65; ca[2] = 7'd66;
        for (int k = 0; k < 4; k++) begin
            step(8'h07, ca, acc);
            gseq[k] = acc;
        end
        check("t2_g0", 64'(gseq[0]), 64'h01);
        check("t2_g1", 64'(gseq[1]), 64'h02);
        check("t2_g2", 64'(gseq[2]), 64'h04);
        check("t2_g3", 64'(gseq[3]), 64'h01);
        for (int k = 0; k < 4; k++) step('0, '0, acc);

        // Out-of-range address: accepted at once, error response, no strobe.
        ca = '0; ca[3] = 7'd96;
        step(8'h08, ca, acc);
        check("t3_acc", 64'(acc), 64'h08);
        for (int k = 0; k < 4; k++) step('0, '0, acc);

        // Bank 0 pointer parked at 7, then P7 beats P0 and the pointer wraps.
        ca = '0; ca[6] = 7'd3;
        step(8'h40, ca, acc);
        ca = '0; ca[7] = 7'd10; ca[0] = 7'd11;
        step(8'h81, ca, acc);
        check("t4_p7", 64'(acc), 64'h80);
        step(8'h81, ca, acc);
        check("t4_p0", 64'(acc), 64'h01);
        for (int k = 0; k < 4; k++) step('0, '0, acc);

        // Reset right after an accept drops the read; arbitration restarts at port 0.
        ca = '0; ca[4] = 7'd40;
        step(8'h10, ca, acc);
        check("t5_acc", 64'(acc), 64'h10);
        reset_seq(4);
        ca = '0; ca[5] = 7'd33; ca[1] = 7'd34;
        step(8'h22, ca, acc);
        check("t5_after", 64'(acc), 64'h02);
        for (int k = 0; k < 4; k++) step('0, '0, acc);

        // Random traffic obeying the hold-until-accepted rule.
        cv = '0; ca = '0; acc = '1;
        for (int n = 0; n < 400; n++) begin
            for (int q = 0; q < NP; q++) begin
                if (!(cv[q] && !acc[q])) begin
                    cv[q] = ($urandom_range(0, 9) < 6);
                    if ($urandom_range(0, 9) == 0)
                        ca[q] = AW'($urandom_range(96, 127));
                    else
                        ca[q] = AW'($urandom_range(0, 2) * 32 + $urandom_range(0, 31));
                end
            end
            step(cv, ca, acc);
        end
        for (int k = 0; k < 4; k++) step('0, '0, acc);

`ifdef BANK_CONFLICT_CNT_EN
        reset_seq(2);
        ca = '0; ca[0] = 7'd32; ca[2] = 7'd33;
        for (int k = 0; k < 10; k++) step(8'h05, ca, acc);
        check("t6_cnt9", 64'(conflict_cnt[1]), 64'd9);
        for (int k = 0; k < 65540; k++) step(8'h05, ca, acc);
        step(8'h05, ca, acc);
        check("t6_sat", 64'(conflict_cnt[1]), 64'hFFFF);
        for (int k = 0; k < 4; k++) step('0, '0, acc);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
